fp_div_seq: RTL and testbench
=============================

# fp_div_seq

Sequential IEEE-754 single-precision divider (out = in1 / in2), the companion to the combinational multiplier in the floating-point datapath. It uses the same numeric conventions as the multiplier: hidden-one mantissas, truncation with no rounding, a separate special-case path, and sign = XOR of operand signs. The divider is a restoring radix-2 iterative unit that produces one quotient bit per clock. It connects to the surrounding datapath through valid/ready handshakes on both sides.

## Interface
- No parameters; format fixed at binary32.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  divider can accept operands (high only in IDLE).
- in1  in  32  dividend, IEEE-754 single.
- in2  in  32  divisor, IEEE-754 single.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out  out  32  quotient, IEEE-754 single.

## Operation
- **Operands:** exponent field 0 means zero; denormals are flushed to zero, keeping the sign. Exponent 255 with fraction 0 is Inf; exponent 255 with fraction ≠ 0 is NaN.
- **Special cases** are resolved at acceptance, with sign s = in1[31]^in2[31]:
  - any NaN, 0/0, or Inf/Inf -> 0x7FC00000;
  - x/0 (x ≠ 0) -> {s, 0x7F800000[30:0]};
  - Inf/x -> signed Inf;
  - 0/x and x/Inf -> signed zero.
- **Normal path:**
  - ma = {1, in1[22:0]}, mb = {1, in2[22:0]}.
  - Remainder register r is 25 bits wide and initialised to ma.
  - Exponent register e is 10-bit signed: e = in1[30:23] − in2[30:23] + 127.
- **Per CALC cycle:**
  - if r ≥ mb, shift in quotient bit 1 and set r = (r − mb) << 1;
  - otherwise shift in 0 and set r = r << 1.
  - The quotient register q is 25 bits, filled MSB-first over 25 cycles.
- **NORM:**
  - if q[24] = 1, frac = q[23:1] and exponent = e;
  - otherwise frac = q[22:0] and exponent = e − 1.
  - The remainder is discarded (truncation).
- **Range:** exponent ≥ 255 -> signed Inf; exponent ≤ 0 -> signed zero; otherwise out = {s, exponent[7:0], frac}.
- **FSM:** IDLE, CALC, NORM, DONE.
  - IDLE -> CALC on accept (in_valid & in_ready) when the operands are normal.
  - IDLE -> DONE on accept when a special case applies; out is loaded directly.
  - CALC -> NORM when the 5-bit counter reaches 24 (25 iterations).
  - NORM -> DONE.
  - DONE -> IDLE on out_ready.

## Timing
- **Reset:** state IDLE; in_ready = 1; out_valid = 0; out = 0x00000000; counter, q and r are cleared.
- **Reset mid-operation:** the operation is aborted and no result is produced; outputs take their reset values on the next edge.
- **Accept:** happens on an edge where in_valid & in_ready. Operands are sampled at that edge and need not be held afterwards.
- **Latency, normal operands:** out_valid rises 27 edges after the accepting edge (25 CALC, 1 NORM, plus the DONE register load).
- **Latency, special case:** out_valid rises 1 edge after the accepting edge.
- **Output hold:** out_valid and out stay stable while out_ready = 0. The transfer completes on an edge with out_valid & out_ready; out_valid drops on that edge.
- **Input side:** in_ready = 0 in every state except IDLE, so in_valid is ignored while busy.
- **No overlap:** a new accept is possible no earlier than the edge after the output transfer. Maximum throughput is one normal division per 29 cycles.
- **out_ready outside DONE** has no effect.

## Test plan
- **Basic quotient:** 0x40C00000 / 0x40000000 (6/2) -> 0x40400000. in_ready stays low for the whole operation. out_valid rises exactly 27 edges after accept.
- **Truncation:** 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, not 0x3EAAAAAB). Also 0xBF800000 / 0x3F800000 -> 0xBF800000.
- **Special cases:**
  - 0x3F800000 / 0x00000000 -> 0x7F800000;
  - 0xBF800000 / 0x00000000 -> 0xFF800000;
  - 0/0 -> 0x7FC00000;
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000.
  - Each result must appear 1 edge after accept.
- **Range limits:** 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow). 0x00800000 / 0x40000000 -> 0x00000000 (underflow).
- **Backpressure:** hold out_ready = 0 for 5 cycles after out_valid; out must stay constant and in_valid pulses must be ignored. Release out_ready; the next edge returns the block to IDLE with in_ready = 1.
- **Reset mid-CALC:** drop rst_n at iteration 10. On the next edge in_ready = 1, out_valid = 0 and out = 0. A following 6/2 division then returns 0x40400000.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider, restoring radix-2, one quotient bit per cycle, truncating.
// Latency: result valid 27 edges after accept (normal), 1 edge after accept (special case).
// Backpressure: in_ready only in IDLE; out_valid/out held until out_ready.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [24:0]        q;
  logic [24:0]        r;
  logic [23:0]        mb;
  logic signed [9:0]  e;
  logic               sign;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        s_in;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        special;
  logic [31:0] special_val;

  assign ea     = in1[30:23];
  assign eb     = in2[30:23];
  assign fa     = in1[22:0];
  assign fb     = in2[22:0];
  assign s_in   = in1[31] ^ in2[31];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  // Denormals fall into the zero class because only the exponent field is inspected.
  always_comb begin
    special     = 1'b1;
    special_val = 32'h0000_0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      special_val = 32'h7FC0_0000;
    else if (b_zero)
      special_val = {s_in, 31'h7F80_0000};
    else if (a_inf)
      special_val = {s_in, 8'hFF, 23'd0};
    else if (a_zero || b_inf)
      special_val = {s_in, 31'd0};
    else
      special = 1'b0;
  end

  // r < 2*mb always holds, so the difference fits in 24 bits before the shift.
  logic        ge;
  logic [24:0] r_sub;
  logic [24:0] r_next;

  assign ge     = (r >= {1'b0, mb});
  assign r_sub  = r - {1'b0, mb};
  assign r_next = ge ? {r_sub[23:0], 1'b0} : {r[23:0], 1'b0};

  logic signed [9:0] e_norm;
  logic [22:0]       frac_norm;
  logic [31:0]       norm_res;

  always_comb begin
    e_norm    = q[24] ? e : e - 10'sd1;
    frac_norm = q[24] ? q[23:1] : q[22:0];
    if (e_norm >= 10'sd255)
      norm_res = {sign, 8'hFF, 23'd0};
    else if (e_norm <= 10'sd0)
      norm_res = {sign, 31'd0};
    else
      norm_res = {sign, e_norm[7:0], frac_norm};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= 32'h0000_0000;
      cnt       <= 5'd0;
      q         <= 25'd0;
      r         <= 25'd0;
      mb        <= 24'd0;
      e         <= 10'sd0;
      sign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            sign     <= s_in;
            if (special) begin
              out   <= special_val;
              state <= DONE;
            end else begin
              r     <= {2'b01, fa};
              mb    <= {1'b1, fb};
              e     <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
              q     <= 25'd0;
              cnt   <= 5'd0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q   <= {q[23:0], ge};
          r   <= r_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24)
            state <= NORM;
        end
        NORM: begin
          out   <= norm_res;
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle raises out_valid; later cycles wait for the consumer.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Randomized and directed bench for fp_div_seq against an integer-division reference model.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;

  fp_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Quotient of the hidden-one mantissas scaled by 2^24 equals the 25-bit truncated quotient.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, output bit sp);
    int          ea, eb, ex;
    logic [22:0] fa, fb, frac;
    logic [63:0] ma, mb, quo;
    logic        s;
    bit          az, bz, ai, bi, an, bn;
    logic [7:0]  e8;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    s  = a[31] ^ b[31];
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (fa == 0);
    bi = (eb == 255) && (fb == 0);
    an = (ea == 255) && (fa != 0);
    bn = (eb == 255) && (fb != 0);
    sp = 1'b1;
    if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC0_0000;
    if (bz || ai) return {s, 8'hFF, 23'd0};
    if (az || bi) return {s, 31'd0};
    sp  = 1'b0;
    ma  = 64'(fa) + (64'd1 << 23);
    mb  = 64'(fb) + (64'd1 << 23);
    quo = (ma << 24) / mb;
    ex  = ea - eb + 127;
    if (quo >= (64'd1 << 24)) begin
      frac = 23'(quo >> 1);
    end else begin
      frac = 23'(quo);
      ex   = ex - 1;
    end
    if (ex >= 255) return {s, 8'hFF, 23'd0};
    if (ex <= 0) return {s, 31'd0};
    e8 = 8'(ex);
    return {s, e8, frac};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  ex;
    logic [22:0] fr;
    int          k;
    k  = $urandom_range(0, 11);
    fr = 23'($urandom);
    if (k == 0) begin
      ex = 8'd0;
    end else if (k == 1) begin
      ex = 8'hFF;
      if ($urandom_range(0, 1) == 1) fr = 23'd0;
    end else if (k <= 3) begin
      ex = 8'($urandom_range(1, 254));
    end else begin
      ex = 8'($urandom_range(110, 145));
    end
    return {1'($urandom), ex, fr};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int stall);
    int          lat;
    bit          rdy_seen;
    bit          hold_bad;
    logic [31:0] held;
    @(negedge clk);
    chk({tag, "/idle_rdy"}, 32'(in_ready), 32'd1);
    in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_seen = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      in1 = $urandom; in2 = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/busy_rdy"}, 32'(rdy_seen), 32'd0);
    chk({tag, "/result"}, out, exp_res);
    held     = out;
    hold_bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in1 = $urandom; in2 = $urandom;
      @(negedge clk);
      if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad = 1'b1;
    end
    if (stall > 0) chk({tag, "/hold"}, 32'(hold_bad), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/drain_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "/drain_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a, b, exp_res;
    bit          sp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/out", out, 32'h0);
    rst_n = 1'b1;

    run_op("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 0);
    run_op("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27, 0);
    run_op("neg_one", 32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 27, 1);
    run_op("pos_div0", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1, 0);
    run_op("neg_div0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1, 0);
    run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0);
    run_op("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1, 2);
    run_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 27, 0);
    run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 27, 0);
    run_op("backpressure", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 5);

    // Abort a division partway through CALC.
    @(negedge clk);
    in1 = 32'h40C0_0000; in2 = 32'h4000_0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset/in_ready", 32'(in_ready), 32'd1);
    chk("midreset/out_valid", 32'(out_valid), 32'd0);
    chk("midreset/out", out, 32'h0);
    run_op("after_reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 0);

    for (int i = 0; i < 40; i++) begin
      a = rnd_fp();
      b = rnd_fp();
      exp_res = ref_div(a, b, sp);
      run_op("random", a, b, exp_res, sp ? 1 : 27, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
